// File: rtl/nios_cpu_oci_dct_pkg.sv
// Shared constants and word type for the OCI data-compressed-trace streams.
`timescale 1ns/1ps
package nios_cpu_oci_dct_pkg;

  localparam int DCT_SYM_W = 3;
  localparam int DCT_SLOTS = 10;
  localparam int DCT_BUF_W = DCT_SYM_W * DCT_SLOTS;
  localparam int DCT_CNT_W = 4;

  typedef struct packed {
    logic [DCT_BUF_W-1:0] buffer;
    logic [DCT_CNT_W-1:0] count;
  } dct_word_t;

endpackage

// File: rtl/nios_cpu_oci_dct_outreg.sv
// Output holding register with valid/ready handshake, shared by OCI trace streams.
`timescale 1ns/1ps
import nios_cpu_oci_dct_pkg::*;

module nios_cpu_oci_dct_outreg (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load_i,
  input  dct_word_t word_i,
  input  logic      ready_i,
  output logic      valid_o,
  output dct_word_t word_o,
  output logic      free_o
);

  logic      valid_q, valid_d;
  dct_word_t word_q, word_d;

  // A load wins over retirement so an accepted word can be replaced in the same edge.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (load_i) begin
      valid_d = 1'b1;
      word_d  = word_i;
    end else if (valid_q && ready_i) begin
      valid_d      = 1'b0;
      word_d.count = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/nios_cpu_nios2_oci_dct_packer.sv
// Packs 3-bit trace symbols into 10-slot words with flush and sticky overflow.
// Optional drop counter enabled by NIOS_CPU_OCI_DCT_DROP_CNT_EN.
`timescale 1ns/1ps
import nios_cpu_oci_dct_pkg::*;

module nios_cpu_nios2_oci_dct_packer (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sym_valid,
  input  logic [DCT_SYM_W-1:0] sym_data,
  input  logic                 flush,
  input  logic                 dct_ready,
  output logic                 dct_valid,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic                 busy
`ifdef NIOS_CPU_OCI_DCT_DROP_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int SYM_W = DCT_SYM_W;
  localparam int SLOTS = DCT_SLOTS;
  localparam logic [DCT_CNT_W-1:0] SLOTS_CNT = DCT_CNT_W'(SLOTS);

  logic [DCT_BUF_W-1:0] pack_buf_q, pack_buf_d;
  logic [DCT_CNT_W-1:0] pack_cnt_q, pack_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 overflow_q, overflow_d;

  logic                 accept, drop, xfer, out_free, flush_req;
  logic [DCT_BUF_W-1:0] sym_ext, buf_w;
  logic [DCT_CNT_W-1:0] cnt_w;
  dct_word_t            xfer_word, out_word;

  assign accept    = sym_valid && (pack_cnt_q < SLOTS_CNT);
  assign drop      = sym_valid && !accept;
  assign sym_ext   = DCT_BUF_W'(sym_data);
  assign buf_w     = accept ? (pack_buf_q | (sym_ext << (SYM_W * int'(pack_cnt_q)))) : pack_buf_q;
  assign cnt_w     = pack_cnt_q + DCT_CNT_W'(accept);
  assign flush_req = flush || flush_pend_q;
  // Symbol arriving this cycle counts toward both the full and the flush decision.
  assign xfer      = out_free && ((cnt_w == SLOTS_CNT) || (flush_req && (cnt_w != '0)));

  assign xfer_word.buffer = buf_w;
  assign xfer_word.count  = cnt_w;

  always_comb begin
    pack_buf_d   = buf_w;
    pack_cnt_d   = cnt_w;
    flush_pend_d = flush_pend_q;
    if (xfer) begin
      pack_buf_d   = '0;
      pack_cnt_d   = '0;
      flush_pend_d = 1'b0;
    end else if (flush) begin
      flush_pend_d = (cnt_w != '0);
    end
    overflow_d = overflow_q;
    if (drop) overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_buf_q   <= '0;
      pack_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pack_buf_q   <= pack_buf_d;
      pack_cnt_q   <= pack_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  nios_cpu_oci_dct_outreg u_outreg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (xfer),
    .word_i  (xfer_word),
    .ready_i (dct_ready),
    .valid_o (dct_valid),
    .word_o  (out_word),
    .free_o  (out_free)
  );

  assign dct_buffer = out_word.buffer;
  assign dct_count  = out_word.count;
  assign overflow   = overflow_q;
  assign busy       = (pack_cnt_q != '0) || dct_valid;

`ifdef NIOS_CPU_OCI_DCT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr) drop_cnt_d = '0;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/nios_cpu_nios2_oci_dct_packer.md
Name: nios_cpu_nios2_oci_dct_packer

Overview:
- Data-compressed-trace (DCT) packing stage that sits directly upstream of the OCI trace consumer/test bench.
- Accumulates 3-bit trace symbols from the OCI data-trace logic into a 30-bit word with a 4-bit symbol count.
- Presents each word on dct_buffer/dct_count with a valid/ready handshake.
- Supports explicit flush of partial words and sticky overflow reporting when the consumer stalls.

Parameters:
- SYM_W, 3, bits per trace symbol.
- SLOTS, 10, symbols per packed word; SYM_W*SLOTS = 30 = dct_buffer width; SLOTS must be < 16.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  trace symbol present this cycle.
- sym_data  in  SYM_W  trace symbol.
- flush  in  1  single-cycle request to emit the partial word (e.g. at test_ending).
- dct_ready  in  1  downstream accepts the word.
- dct_valid  out  1  dct_buffer/dct_count hold a word.
- dct_buffer  out  SYM_W*SLOTS  packed symbols, slot 0 at bits [2:0].
- dct_count  out  4  number of valid slots, 1..SLOTS; 0 when dct_valid=0.
- overflow  out  1  sticky: at least one symbol was dropped.
- overflow_clr  in  1  clears overflow.
- busy  out  1  pack count nonzero or dct_valid.

Behaviour:
- Reset (async, reset_n=0):
  - pack buffer=0, pack count=0, dct_valid=0, dct_buffer=0, dct_count=0, overflow=0.
  - Reset mid-word discards all contents with no emission.
- Two storage stages: pack register (buffer+count) and output register (dct_*). Define out_free = !dct_valid | dct_ready.
- Symbol acceptance:
  - Accept when sym_valid and pack count < SLOTS.
  - Write symbol to slot [SYM_W*cnt +: SYM_W] and increment count.
  - Unwritten slots always read 0.
- Transfer pack->output register occurs at the clock edge when out_free and either:
  - the pack count reaches SLOTS (including via the symbol accepted this cycle), or
  - flush=1 and count (including this cycle's symbol) > 0.
- On transfer:
  - pack count clears to 0 and the pack buffer clears to 0.
  - dct_valid=1 next cycle. Latency from the 10th symbol to dct_valid is 1 cycle.
- Full pack with !out_free:
  - Pack holds at count=SLOTS.
  - Further sym_valid symbols are dropped and set overflow.
  - Transfer occurs on the first out_free cycle.
- Flush with !out_free: the flush is remembered in a pending bit and executes on the first out_free cycle. Symbols accepted meanwhile join the flushed word.
- flush with count=0 and no symbol: no word emitted; clears the pending bit.
- Handshake rules:
  - While dct_valid & !dct_ready, dct_buffer/dct_count remain stable.
  - dct_valid & dct_ready with no new transfer: dct_valid=0 and dct_count=0 next cycle; dct_buffer is held.
- Back-to-back operation: a continuous symbol stream with dct_ready=1 emits one word every 10 cycles with no drops.
- overflow:
  - Set on drop.
  - overflow_clr clears it.
  - If a drop and a clear occur in the same cycle, set wins.
- busy is combinational from registered state.

Optional Feature:
- Macro: NIOS_CPU_OCI_DCT_DROP_CNT_EN.
- Defined: adds output drop_count (16 bits), which increments on every dropped symbol and saturates at 0xFFFF. overflow_clr also zeroes it. Reset value 0.
- Undefined: port and counter absent; overflow is the only drop indication.

Decomposition:
- Shared package nios_cpu_oci_dct_pkg holds:
  - constants DCT_SYM_W=3, DCT_SLOTS=10, DCT_BUF_W=30, DCT_CNT_W=4;
  - typedef dct_word_t {buffer, count}.
- One natural sub-module: nios_cpu_oci_dct_outreg, the output holding register with valid/ready, reused by other OCI trace streams.

Test Plan:
- Reset, then 10 symbols 0..7,0,1 with dct_ready=1 -> one cycle later dct_valid=1, dct_count=10, dct_buffer=30'o1076543210 (octal, slot 0 LSB).
- 3 symbols 5,6,7, then flush pulse -> next cycle dct_count=3, dct_buffer=30'o765; flush with empty pack -> no dct_valid.
- dct_ready=0, 25 symbols -> first word valid and stable, second pack full, last 5 dropped, overflow=1. Then dct_ready=1 -> two words emitted in consecutive handshakes, with no corruption.
- 10th symbol arrives in the same cycle the previous word is accepted (dct_ready=1) -> new word valid the next cycle, no gap and no drop.
- reset_n asserted with count=6 and dct_valid=1 -> all outputs 0 immediately; after release, 1 symbol plus flush -> dct_count=1.
- With NIOS_CPU_OCI_DCT_DROP_CNT_EN defined: drop 7 symbols -> drop_count=7; overflow_clr -> 0. Forced 70000 drops -> drop_count saturates at 0xFFFF.
